// File: rtl/mmda_pkg.sv
// rtl/mmda_pkg.sv - shared constants and sequencer phase type for the mmda block
package mmda_pkg;
    localparam int DW      = 8;
    localparam int N       = 3;
    localparam int ACC_W   = 2*DW + 2;
    localparam int LUT_W   = DW + 2;
    localparam int CNT_MAX = 8;

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_ACCUM,
        PH_LAST
    } phase_t;
endpackage

// File: rtl/mmda_da_row.sv
// rtl/mmda_da_row.sv - one matrix row: 8-entry partial-sum LUT plus shift-accumulator
module da_row #(
    parameter int DW = mmda_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] x0,
    input  logic [DW-1:0] x1,
    input  logic [DW-1:0] x2,
    input  logic [2:0]    addr,
    output logic [DW-1:0] acc
);
    localparam int AW = 2*DW + 2;
    localparam int LW = DW + 2;

    logic [LW-1:0] lut [8];
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_nxt;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lut[i] = (i[0] ? LW'(x0) : '0) + (i[1] ? LW'(x1) : '0) + (i[2] ? LW'(x2) : '0);
        end
    end

    assign acc_nxt = (acc_q << 1) + AW'(lut[addr]);

    // Exposes the post-step value so the top can latch a result on the same edge as the last step.
    assign acc = acc_nxt[DW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_nxt;
        end
    end
endmodule

// File: rtl/mmda.sv
// rtl/mmda.sv - 3x3 matrix by vector product using bit-serial distributed arithmetic
module mmda #(
    parameter int DW = mmda_pkg::DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] e,
    input  logic [DW-1:0] f,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] h,
    input  logic [DW-1:0] j,
    input  logic [DW-1:0] c0,
    input  logic [DW-1:0] c1,
    input  logic [DW-1:0] c2,
    output logic [DW-1:0] y0,
    output logic [DW-1:0] y1,
    output logic [DW-1:0] y2,
    input  logic          clk,
    input  logic          reset
);
    import mmda_pkg::*;

    localparam int CW = $clog2(DW + 1);
    localparam int IW = $clog2(DW);

    logic [CW-1:0] cnt, cnt_nxt;
    phase_t        phase;
    logic          clr, en, y_load;
    logic [IW-1:0] bit_idx;
    logic [2:0]    addr;

    logic [DW-1:0] ar, br, cr, dr, er, fr, gr, hr, jr, c0r, c1r, c2r;
    logic [DW-1:0] r0, r1, r2;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        phase = PH_ACCUM;
        if (cnt == '0) begin
            phase = PH_LOAD;
        end else if (cnt == CW'(DW)) begin
            phase = PH_LAST;
        end
        cnt_nxt = cnt + 1'b1;
        if (phase == PH_LAST) begin
            cnt_nxt = '0;
        end
    end

    // Bit slices are walked MSB first: cnt=1 selects bit DW-1, cnt=DW selects bit 0.
    always_comb begin
        clr     = (phase == PH_LOAD);
        en      = (phase != PH_LOAD);
        y_load  = (phase == PH_LAST);
        bit_idx = IW'(CW'(DW) - cnt);
        addr    = '0;
        if (phase != PH_LOAD) begin
            addr = {c2r[bit_idx], c1r[bit_idx], c0r[bit_idx]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {ar, br, cr, dr, er, fr, gr, hr, jr} <= '0;
            {c0r, c1r, c2r} <= '0;
            {y0, y1, y2} <= '0;
        end else begin
            if (phase == PH_LOAD) begin
                {ar, br, cr, dr, er, fr, gr, hr, jr} <= {a, b, c, d, e, f, g, h, j};
                {c0r, c1r, c2r} <= {c0, c1, c2};
            end
            if (y_load) begin
                y0 <= r0;
                y1 <= r1;
                y2 <= r2;
            end
        end
    end

    da_row #(.DW(DW)) u_row0 (
        .clk(clk), .reset(reset), .clr(clr), .en(en),
        .x0(ar), .x1(br), .x2(cr), .addr(addr), .acc(r0)
    );

    da_row #(.DW(DW)) u_row1 (
        .clk(clk), .reset(reset), .clr(clr), .en(en),
        .x0(dr), .x1(er), .x2(fr), .addr(addr), .acc(r1)
    );

    da_row #(.DW(DW)) u_row2 (
        .clk(clk), .reset(reset), .clr(clr), .en(en),
        .x0(gr), .x1(hr), .x2(jr), .addr(addr), .acc(r2)
    );
endmodule

// File: tb/tb_mmda.sv
// tb/tb_mmda.sv - scoreboard bench for the mmda matrix-vector block
module tb_mmda;
    logic       clk;
    logic       reset;
    logic [7:0] a, b, c, d, e, f, g, h, j, c0, c1, c2;
    logic [7:0] y0, y1, y2;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q [$];
    logic [23:0] held;

    mmda dut (
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .j(j),
        .c0(c0), .c1(c1), .c2(c2),
        .y0(y0), .y1(y1), .y2(y2),
        .clk(clk), .reset(reset)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dot(input logic [7:0] x0, x1, x2, v0, v1, v2);
        int s;
        s = int'(x0) * int'(v0) + int'(x1) * int'(v1) + int'(x2) * int'(v2);
        return s[7:0];
    endfunction

    task automatic set_seq();
        {a, b, c, d, e, f, g, h, j} = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    endtask

    task automatic set_all(input logic [7:0] v);
        {a, b, c, d, e, f, g, h, j} = {v, v, v, v, v, v, v, v, v};
    endtask

    task automatic set_vec(input logic [7:0] v0, v1, v2);
        c0 = v0; c1 = v1; c2 = v2;
    endtask

    // Runs one frame starting at a LOAD edge; outputs must hold until the 9th edge delivers the result.
    task automatic run_frame(input string name, input int change_at, input logic [7:0] new_c0);
        logic [23:0] want;
        exp_q.push_back({dot(a, b, c, c0, c1, c2), dot(d, e, f, c0, c1, c2), dot(g, h, j, c0, c1, c2)});
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (k < 9) begin
                if ({y0, y1, y2} !== held) begin
                    errors++;
                    $display("FAIL %s hold k=%0d got=%h want=%h", name, k, {y0, y1, y2}, held);
                end
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s result queue empty got=%h", name, {y0, y1, y2});
            end else begin
                want = exp_q.pop_front();
                if ({y0, y1, y2} !== want) begin
                    errors++;
                    $display("FAIL %s result got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", name,
                             y0, y1, y2, want[23:16], want[15:8], want[7:0]);
                end
                held = want;
            end
            if (k == change_at) c0 = new_c0;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        set_all(8'd77);
        set_vec(8'd3, 8'd4, 8'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({y0, y1, y2} !== 24'h0) begin
            errors++;
            $display("FAIL reset_state got=%h want=000000", {y0, y1, y2});
        end
        held = '0;
    endtask

    task automatic test_basic();
        set_seq();
        set_vec(8'd1, 8'd2, 8'd3);
        reset = 0;
        run_frame("basic", -1, 8'd0);
        checks++;
        if ({y0, y1, y2} !== {8'd14, 8'd32, 8'd50}) begin
            errors++;
            $display("FAIL basic_const got=(%0d,%0d,%0d) want=(14,32,50)", y0, y1, y2);
        end
    endtask

    task automatic test_identity();
        set_all(8'd0);
        a = 8'd1; e = 8'd1; j = 8'd1;
        set_vec(8'd5, 8'd6, 8'd7);
        for (int n = 0; n < 4; n++) run_frame("identity", -1, 8'd0);
    endtask

    task automatic test_wrap();
        set_all(8'd255);
        set_vec(8'd255, 8'd255, 8'd255);
        run_frame("wrap", -1, 8'd0);
        checks++;
        if ({y0, y1, y2} !== {8'd3, 8'd3, 8'd3}) begin
            errors++;
            $display("FAIL wrap_const got=(%0d,%0d,%0d) want=(3,3,3)", y0, y1, y2);
        end
    endtask

    task automatic test_midframe_change();
        set_seq();
        set_vec(8'd1, 8'd2, 8'd3);
        run_frame("mid_cur", 4, 8'd0);
        run_frame("mid_next", -1, 8'd0);
    endtask

    task automatic test_reset_midframe();
        set_seq();
        set_vec(8'd1, 8'd2, 8'd3);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({y0, y1, y2} !== held) begin
                errors++;
                $display("FAIL rst_mid hold k=%0d got=%h want=%h", k, {y0, y1, y2}, held);
            end
        end
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        held = '0;
        checks++;
        if ({y0, y1, y2} !== 24'h0) begin
            errors++;
            $display("FAIL rst_mid clear got=%h want=000000", {y0, y1, y2});
        end
        run_frame("rst_fresh", -1, 8'd0);
    endtask

    task automatic test_glitch();
        set_vec(8'd9, 8'd8, 8'd7);
        reset = 1;
        #2;
        reset = 0;
        run_frame("glitch", -1, 8'd0);
    endtask

    task automatic test_zero();
        set_all(8'd0);
        set_vec(8'd200, 8'd17, 8'd99);
        run_frame("zero_a", -1, 8'd0);
        set_vec(8'd255, 8'd1, 8'd128);
        run_frame("zero_b", -1, 8'd0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            {a, b, c, d, e, f} = {8'($urandom), 8'($urandom), 8'($urandom),
                                  8'($urandom), 8'($urandom), 8'($urandom)};
            {g, h, j} = {8'($urandom), 8'($urandom), 8'($urandom)};
            set_vec(8'($urandom), 8'($urandom), 8'($urandom));
            run_frame("b2b", -1, 8'd0);
        end
    endtask

    initial begin
        clk = 0;
        reset = 1;
        set_all(8'd0);
        set_vec(8'd0, 8'd0, 8'd0);
        held = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_identity();
        test_wrap();
        test_midframe_change();
        test_reset_midframe();
        test_glitch();
        test_zero();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
